// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU command codes,
// shifter types, status bit positions and a rotate helper.
package arm_defs;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

    function automatic logic [31:0] ror32(
        input logic [31:0] x,
        input logic [4:0]  amt
    );
        logic [63:0] t;
        t = {x, x} >> amt;
        return t[31:0];
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE register fields into the execute stage and its results
// toward EXE/MEM, IF branch control and the ID condition check.
interface exe_stage_if;

    logic [3:0]  EXE_CMD;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        S;
    logic        B;
    logic [31:0] PC;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic        imm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [31:0] ALU_Res;
    logic [31:0] Br_addr;
    logic        Br_taken;
    logic [3:0]  Status;

    modport master (
        output EXE_CMD, MEM_R_EN, MEM_W_EN, S, B, PC,
        output Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24,
        input  ALU_Res, Br_addr, Br_taken, Status
    );

    modport slave (
        input  EXE_CMD, MEM_R_EN, MEM_W_EN, S, B, PC,
        input  Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24,
        output ALU_Res, Br_addr, Br_taken, Status
    );

endinterface

// File: rtl/exe_stage_status.sv
// Architectural NZCV register with synchronous reset and load.
module status_register (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ld,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    logic [3:0] r_q;

    always_ff @(posedge clk) begin
        if (rst)
            r_q <= 4'b0000;
        else if (i_ld)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/exe_stage_val2.sv
// Second-operand generator: memory offset, rotated immediate,
// or immediate-amount shift of Rm.
module val2_generator
    import arm_defs::*;
(
    input  logic        i_mem_en,
    input  logic        i_imm,
    input  logic [11:0] i_shift_op,
    input  logic [31:0] i_val_rm,
    output logic [31:0] o_val2
);

    logic [4:0]  w_rot_amt;
    logic [31:0] w_imm_val;
    logic [4:0]  w_sh_amt;
    shift_t      w_sh_type;
    logic [31:0] w_sh_val;

    assign w_rot_amt = {i_shift_op[11:8], 1'b0};
    assign w_imm_val = ror32({24'b0, i_shift_op[7:0]}, w_rot_amt);
    assign w_sh_amt  = i_shift_op[11:7];
    assign w_sh_type = shift_t'(i_shift_op[6:5]);

    // A zero amount falls out as a pass-through for every type.
    always_comb begin
        w_sh_val = i_val_rm;
        case (w_sh_type)
            SH_LSL:  w_sh_val = i_val_rm << w_sh_amt;
            SH_LSR:  w_sh_val = i_val_rm >> w_sh_amt;
            SH_ASR:  w_sh_val = $unsigned($signed(i_val_rm) >>> w_sh_amt);
            SH_ROR:  w_sh_val = ror32(i_val_rm, w_sh_amt);
            default: w_sh_val = i_val_rm;
        endcase
    end

    always_comb begin
        o_val2 = w_sh_val;
        if (i_mem_en)
            o_val2 = {20'b0, i_shift_op};
        else if (i_imm)
            o_val2 = w_imm_val;
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU with NZCV flags, status
// register and branch target adder.
module exe_stage
    import arm_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    exe_stage_if.slave   bus
);

    logic [WIDTH-1:0] w_val2;
    logic [WIDTH-1:0] w_rn;
    logic [WIDTH-1:0] w_op2;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_cy;
    logic             w_arith;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_status;
    logic [3:0]       w_flags;
    logic [WIDTH-1:0] w_br_off;

    assign w_rn = bus.Val_Rn;

    val2_generator u_val2 (
        .i_mem_en   (bus.MEM_R_EN | bus.MEM_W_EN),
        .i_imm      (bus.imm),
        .i_shift_op (bus.Shift_operand),
        .i_val_rm   (bus.Val_Rm),
        .o_val2     (w_val2)
    );

    // Subtraction runs through the adder as Rn + ~Val2 + carry-in.
    always_comb begin
        w_op2   = w_val2;
        w_cy    = 1'b0;
        w_arith = 1'b0;
        w_res   = '0;
        w_c     = w_status[ST_C];
        w_v     = w_status[ST_V];
        case (bus.EXE_CMD)
            CMD_MOV: w_res = w_val2;
            CMD_MVN: w_res = ~w_val2;
            CMD_AND: w_res = w_rn & w_val2;
            CMD_ORR: w_res = w_rn | w_val2;
            CMD_EOR: w_res = w_rn ^ w_val2;
            CMD_ADD: w_arith = 1'b1;
            CMD_ADC: begin
                w_arith = 1'b1;
                w_cy    = w_status[ST_C];
            end
            CMD_SUB: begin
                w_arith = 1'b1;
                w_op2   = ~w_val2;
                w_cy    = 1'b1;
            end
            CMD_SBC: begin
                w_arith = 1'b1;
                w_op2   = ~w_val2;
                w_cy    = w_status[ST_C];
            end
            default: w_res = '0;
        endcase
        w_sum = {1'b0, w_rn} + {1'b0, w_op2} + {{WIDTH{1'b0}}, w_cy};
        if (w_arith) begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (w_rn[WIDTH-1] == w_op2[WIDTH-1])
                 && (w_res[WIDTH-1] != w_rn[WIDTH-1]);
        end
    end

    assign w_flags[ST_N] = w_res[WIDTH-1];
    assign w_flags[ST_Z] = (w_res == '0);
    assign w_flags[ST_C] = w_c;
    assign w_flags[ST_V] = w_v;

    status_register u_status (
        .clk  (clk),
        .rst  (rst),
        .i_ld (bus.S),
        .i_d  (w_flags),
        .o_q  (w_status)
    );

    assign w_br_off = {{6{bus.Signed_imm_24[23]}}, bus.Signed_imm_24, 2'b00};

    assign bus.ALU_Res  = w_res;
    assign bus.Br_addr  = bus.PC + w_br_off;
    assign bus.Br_taken = bus.B;
    assign bus.Status   = w_status;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: ALU results via scoreboard,
// status register, shifter, carry chain and branch target.
module tb_exe_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] sb[$];

    exe_stage_if bus();

    exe_stage #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.EXE_CMD       = 4'd0;
        bus.MEM_R_EN      = 1'b0;
        bus.MEM_W_EN      = 1'b0;
        bus.S             = 1'b0;
        bus.B             = 1'b0;
        bus.PC            = 32'd0;
        bus.Val_Rn        = 32'd0;
        bus.Val_Rm        = 32'd0;
        bus.imm           = 1'b0;
        bus.Shift_operand = 12'd0;
        bus.Signed_imm_24 = 24'd0;
    endtask

    task automatic apply(
        input logic [3:0]  cmd,
        input logic        mr,
        input logic        mw,
        input logic        s,
        input logic [31:0] rn,
        input logic [31:0] rm,
        input logic        im,
        input logic [11:0] sh,
        input logic [31:0] exp_res
    );
        @(negedge clk);
        bus.EXE_CMD       = cmd;
        bus.MEM_R_EN      = mr;
        bus.MEM_W_EN      = mw;
        bus.S             = s;
        bus.Val_Rn        = rn;
        bus.Val_Rm        = rm;
        bus.imm           = im;
        bus.Shift_operand = sh;
        sb.push_back(exp_res);
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst = 1'b1;
        apply(4'b0010, 0, 0, 1, 32'h7FFFFFFF, 32'h1, 0, 12'h0, 32'h80000000);
        e = sb.pop_front();
        checks++;
        if (bus.ALU_Res !== e) begin
            errors++;
            $display("FAIL rst_alu: got %h expected %h", bus.ALU_Res, e);
        end
        tick();
        checks++;
        if (bus.Status !== 4'b0000) begin
            errors++;
            $display("FAIL rst_status: got %b expected 0000", bus.Status);
        end
        rst = 1'b0;
    endtask

    task automatic test_flags();
        logic [31:0] e;
        logic [3:0]  st[5];
        st = '{4'b1001, 4'b0110, 4'b0110, 4'b0111, 4'b0011};
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: apply(4'b0010, 0, 0, 1, 32'h7FFFFFFF, 32'h1, 0, 12'h000, 32'h80000000);
                1: apply(4'b0100, 0, 0, 1, 32'h5, 32'h0, 1, 12'h005, 32'h0);
                2: apply(4'b0001, 0, 0, 0, 32'h0, 32'h0, 1, 12'h4FF, 32'hFF000000);
                3: apply(4'b0010, 0, 0, 1, 32'h80000000, 32'h80000000, 0, 12'h000, 32'h0);
                default: apply(4'b0111, 0, 0, 1, 32'h1, 32'h0, 1, 12'h002, 32'h3);
            endcase
            e = sb.pop_front();
            checks++;
            if (bus.ALU_Res !== e) begin
                errors++;
                $display("FAIL flags_alu[%0d]: got %h expected %h", i, bus.ALU_Res, e);
            end
            tick();
            checks++;
            if (bus.Status !== st[i]) begin
                errors++;
                $display("FAIL flags_status[%0d]: got %b expected %b", i, bus.Status, st[i]);
            end
        end
    endtask

    task automatic test_logic_preserve();
        logic [31:0] e;
        logic [3:0]  st[4];
        st = '{4'b0111, 4'b1011, 4'b1011, 4'b0111};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: apply(4'b1111, 0, 0, 1, 32'h5, 32'h7, 0, 12'h000, 32'h0);
                1: apply(4'b1000, 0, 0, 1, 32'hFFFFFFFF, 32'h0, 1, 12'h0FF, 32'hFFFFFF00);
                2: apply(4'b1001, 0, 0, 1, 32'h0, 32'h0, 1, 12'h000, 32'hFFFFFFFF);
                default: apply(4'b0110, 0, 0, 1, 32'hF0, 32'h0, 1, 12'h00F, 32'h0);
            endcase
            e = sb.pop_front();
            checks++;
            if (bus.ALU_Res !== e) begin
                errors++;
                $display("FAIL logic_alu[%0d]: got %h expected %h", i, bus.ALU_Res, e);
            end
            tick();
            checks++;
            if (bus.Status !== st[i]) begin
                errors++;
                $display("FAIL logic_status[%0d]: got %b expected %b", i, bus.Status, st[i]);
            end
        end
    endtask

    task automatic test_shifter();
        logic [31:0] e;
        logic [3:0]  cmd[7];
        logic [11:0] sh[7];
        logic [31:0] ex[7];
        cmd = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1001};
        sh  = '{{5'd4, 2'b00, 5'b0}, {5'd4, 2'b01, 5'b0}, {5'd4, 2'b10, 5'b0},
                {5'd4, 2'b11, 5'b0}, {5'd0, 2'b10, 5'b0}, {5'd8, 2'b11, 5'b0},
                {5'd4, 2'b00, 5'b0}};
        ex  = '{32'h00000100, 32'h08000001, 32'hF8000001, 32'h08000001,
                32'h80000010, 32'h10800000, 32'hFFFFFEFF};
        for (int i = 0; i < 7; i++) begin
            apply(cmd[i], 0, 0, 0, 32'h0, 32'h80000010, 0, sh[i], ex[i]);
            e = sb.pop_front();
            checks++;
            if (bus.ALU_Res !== e) begin
                errors++;
                $display("FAIL shift[%0d]: got %h expected %h", i, bus.ALU_Res, e);
            end
            tick();
        end
    endtask

    task automatic test_carry_chain();
        logic [31:0] e;
        logic [3:0]  st[7];
        st = '{4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0010};
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: apply(4'b0100, 0, 0, 1, 32'h5, 32'h0, 1, 12'h005, 32'h0);
                1: apply(4'b0011, 0, 0, 0, 32'h1, 32'h0, 1, 12'h001, 32'h3);
                2: apply(4'b0011, 0, 0, 1, 32'h1, 32'h0, 1, 12'h001, 32'h3);
                3: apply(4'b0011, 0, 0, 0, 32'h1, 32'h0, 1, 12'h001, 32'h2);
                4: apply(4'b0101, 0, 0, 0, 32'h5, 32'h0, 1, 12'h002, 32'h2);
                5: apply(4'b0100, 0, 0, 1, 32'h5, 32'h0, 1, 12'h005, 32'h0);
                default: apply(4'b0101, 0, 0, 1, 32'h5, 32'h0, 1, 12'h002, 32'h3);
            endcase
            e = sb.pop_front();
            checks++;
            if (bus.ALU_Res !== e) begin
                errors++;
                $display("FAIL carry_alu[%0d]: got %h expected %h", i, bus.ALU_Res, e);
            end
            tick();
            checks++;
            if (bus.Status !== st[i]) begin
                errors++;
                $display("FAIL carry_status[%0d]: got %b expected %b", i, bus.Status, st[i]);
            end
        end
        test_reset();
    endtask

    task automatic test_mem_offset();
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0)
                apply(4'b0010, 1, 0, 0, 32'h0, 32'hDEADBEEF, 0, 12'hFFC, 32'h00000FFC);
            else
                apply(4'b0010, 0, 1, 0, 32'h1000, 32'h12345678, 1, 12'h800, 32'h00001800);
            e = sb.pop_front();
            checks++;
            if (bus.ALU_Res !== e) begin
                errors++;
                $display("FAIL mem[%0d]: got %h expected %h", i, bus.ALU_Res, e);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [31:0] pc[3];
        logic [23:0] off[3];
        logic        b[3];
        logic [31:0] ex[3];
        pc  = '{32'h100, 32'h100, 32'hFFFFFFFC};
        off = '{24'hFFFFFE, 24'h000003, 24'h000001};
        b   = '{1'b1, 1'b1, 1'b0};
        ex  = '{32'h000000F8, 32'h0000010C, 32'h00000000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.PC            = pc[i];
            bus.Signed_imm_24 = off[i];
            bus.B             = b[i];
            #2;
            checks++;
            if (bus.Br_addr !== ex[i]) begin
                errors++;
                $display("FAIL br_addr[%0d]: got %h expected %h", i, bus.Br_addr, ex[i]);
            end
            checks++;
            if (bus.Br_taken !== b[i]) begin
                errors++;
                $display("FAIL br_taken[%0d]: got %b expected %b", i, bus.Br_taken, b[i]);
            end
            tick();
        end
        checks++;
        if (bus.Status !== 4'b0000) begin
            errors++;
            $display("FAIL br_status: got %b expected 0000", bus.Status);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.Status !== 4'b0000) begin
            errors++;
            $display("FAIL init_status: got %b expected 0000", bus.Status);
        end
        rst = 1'b0;
        test_flags();
        test_logic_preserve();
        test_shifter();
        test_carry_chain();
        test_mem_offset();
        test_branch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline; consumes the decoded, registered fields from the ID/EXE pipeline register.
- Generates the second operand (Val2) from immediate or shifter fields and computes the ALU result and the branch target.
- Holds the architectural NZCV status register. The ID stage reads it for condition checks; ADC/SBC use its C flag.
- Outputs feed the EXE/MEM pipeline register and IF stage branch control.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous active-high reset
- EXE_CMD  in  4  ALU command
- MEM_R_EN  in  1  load instruction in EXE
- MEM_W_EN  in  1  store instruction in EXE
- S  in  1  update status register this cycle
- B  in  1  branch instruction in EXE
- PC  in  32  PC+4 of instruction in EXE
- Val_Rn  in  32  first operand
- Val_Rm  in  32  register second operand
- imm  in  1  immediate operand select
- Shift_operand  in  12  shifter field [11:0]
- Signed_imm_24  in  24  branch offset
- ALU_Res  out  32  ALU result / memory address
- Br_addr  out  32  branch target
- Br_taken  out  1  equals B (drives IF mux and pipeline flush)
- Status  out  4  registered {N,Z,C,V}

Behaviour:
- Clock and reset:
  - One clock domain.
  - On rst (sampled at posedge clk): Status <= 4'b0000; rst takes priority over S.
  - All other outputs are combinational from inputs and Status; there are no internal registers besides Status.
- Val2 priority:
  1. If MEM_R_EN|MEM_W_EN: zero-extend Shift_operand[11:0].
  2. Else if imm: {24'b0, Shift_operand[7:0]} rotated right by 2*Shift_operand[11:8].
  3. Else: shift Val_Rm by Shift_operand[11:7]; Shift_operand[6:5] selects the type:
     - 00 LSL, 01 LSR, 10 ASR, 11 ROR.
     - An amount of 0 passes Val_Rm unchanged for all types; register-specified shift is not supported.
- ALU commands (C_in = Status[1]):
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD / LDR / STR: Rn+Val2
  - 0011 ADC: Rn+Val2+C_in
  - 0100 SUB / CMP: Rn-Val2
  - 0101 SBC: Rn-Val2-!C_in
  - 0110 AND / TST: Rn&Val2
  - 0111 ORR: Rn|Val2
  - 1000 EOR: Rn^Val2
  - Any other code: result 0, C and V preserved.
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops: C is the 33rd bit of the 33-bit sum. Subtraction is computed as Rn+~Val2+1 (SBC as Rn+~Val2+C_in), so C=1 means no borrow.
  - V is signed overflow: set when the operand signs are equal (using ~Val2 for subtraction) and the result sign differs.
  - Logical ops and MOV/MVN preserve the current C and V.
- Status register:
  - At posedge clk, if !rst && S: Status <= {N,Z,C,V}; otherwise it holds.
  - The new value is visible one cycle after the instruction is in EXE.
  - A simultaneous read by ADC/SBC in the same cycle uses the old value.
- Branch:
  - Br_addr = PC + ({{6{Signed_imm_24[23]}}, Signed_imm_24} << 2), wrapping mod 2^32.
  - Br_addr is driven regardless of B; Br_taken = B.
- Flushed or bubble instructions arrive with all controls 0 (EXE_CMD=0, S=0), so Status never changes for a bubble.

Decomposition:
- Shared package (arm_defs):
  - EXE_CMD encodings as named constants.
  - Shift-type codes.
  - Status bit indices N=3, Z=2, C=1, V=0.
- Natural sub-modules:
  - val2_generator: combinational shifter/rotator.
  - status_register: 4-bit register with synchronous reset and load enable.
- ALU and branch adder are inline.

Test Plan:
- ADD with S=1, Rn=32'h7FFFFFFF, Val_Rm=1, Shift_operand=0 -> ALU_Res=32'h80000000. Next cycle Status=4'b1001 (N=1, V=1).
- SUB/CMP with S=1, Rn=5, imm=1, Shift_operand=12'h005 -> ALU_Res=0. Next cycle Status=4'b0110 (Z=1, C=1 no borrow).
- imm=1, Shift_operand=12'h4FF, MOV -> Val2 = 0xFF ror 8 = 32'hFF000000 = ALU_Res. With S=0, Status is unchanged.
- Shifter ASR: Val_Rm=32'h80000010, Shift_operand={5'd4, 2'b10, 5'b0}, MOV -> ALU_Res=32'hF8000001. LSL/LSR/ROR covered with the same Val_Rm.
- Carry chain: preload Status C=1, then ADC Rn=1, Val2=1 -> 3. With C=0, SBC Rn=5, Val2=2 -> 2. Reset asserted together with S=1 -> Status=0.
- Branch: PC=32'h100, Signed_imm_24=24'hFFFFFE, B=1 -> Br_addr=32'hF8, Br_taken=1. With 24'h000003 -> 32'h10C. LDR with Shift_operand=12'hFFC, Rn=0 -> ALU_Res=32'hFFC (no sign extension).
